// File: rtl/seq_pkg.sv
// Shared definitions for the LED sequence display controller:
// the FSM state encoding, datapath widths and default timing parameters.
package seq_pkg;

  localparam int ADDR_W = 4;
  localparam int LED_W  = 4;

  // 25_000_000 cycles of a 50 MHz clock gives a 0.5 s tick
  localparam int DEF_CLK_DIV   = 25_000_000;
  localparam int DEF_ON_TICKS  = 2;
  localparam int DEF_OFF_TICKS = 1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_ON   = 3'd2,
    ST_OFF  = 3'd3,
    ST_DONE = 3'd4
  } seq_state_e;

  // Width needed to hold the values 0..n-1, never less than one bit
  function automatic int cntWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int maxInt(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/seq_tick_gen.sv
// Tick prescaler: counts enabled cycles and emits a one-cycle tick when the
// count reaches CLK_DIV-1, wrapping to 0 on that cycle. A synchronous clear
// restarts the count; while enable is low the count is held.
module seq_tick_gen
  import seq_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic tick_o
);

  localparam int              CNT_W    = cntWidth(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             atLast;

  assign atLast = (cnt_q == CNT_LAST);
  assign tick_o = enable_i && !clear_i && atLast;

  // Next count: clear wins, otherwise advance and wrap while enabled
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = atLast ? '0 : (cnt_q + CNT_ONE);
    end
  end

  // Prescaler register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/seq_display_ctrl.sv
// LED sequence display controller. On start it reads len+1 one-hot patterns
// from an external ROM and shows each one for ON_TICKS ticks followed by
// OFF_TICKS blank ticks, then reports completion on end_fpga.
// Optional feature macro: SEQ_PAUSE_EN (pause input freezes playback).
module seq_display_ctrl
  import seq_pkg::*;
#(
  parameter int CLK_DIV   = DEF_CLK_DIV,
  parameter int ON_TICKS  = DEF_ON_TICKS,
  parameter int OFF_TICKS = DEF_OFF_TICKS
) (
  input  logic              clock_50,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] len,
  input  logic              pause,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [LED_W-1:0]  rom_data,
  output logic [LED_W-1:0]  leds,
  output logic              busy,
  output logic              end_fpga
);

  // The tick counter only needs to reach the larger of the two phase lengths
  localparam int             TC_W     = cntWidth(maxInt(ON_TICKS, OFF_TICKS));
  localparam logic [TC_W-1:0] ON_LAST  = TC_W'(ON_TICKS - 1);
  localparam logic [TC_W-1:0] OFF_LAST = TC_W'(OFF_TICKS - 1);
  localparam logic [TC_W-1:0] TC_ONE   = TC_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [ADDR_W-1:0] len_q,   len_d;
  logic [LED_W-1:0]  leds_q,  leds_d;
  logic [TC_W-1:0]   tcnt_q,  tcnt_d;

  logic inPhase;
  logic playHold;
  logic tick;

  // Playback freeze: only meaningful while a sequence is in flight
`ifdef SEQ_PAUSE_EN
  assign playHold = pause && ((state_q == ST_LOAD) || (state_q == ST_ON) ||
                              (state_q == ST_OFF));
`else
  logic unused_pause;
  assign unused_pause = pause;
  assign playHold     = 1'b0;
`endif

  assign inPhase = (state_q == ST_ON) || (state_q == ST_OFF);

  // Prescaler runs only during the lit and blank phases; it is cleared in
  // every other state so each phase starts from a full tick period
  seq_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_gen (
    .clk_i    (clock_50),
    .rst_ni   (reset),
    .clear_i  (!inPhase),
    .enable_i (inPhase && !playHold),
    .tick_o   (tick)
  );

  // Sequencing FSM and its datapath next-state logic
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    leds_d  = leds_q;
    tcnt_d  = tcnt_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        leds_d = '0;
        tcnt_d = '0;
        if (start) begin
          state_d = ST_LOAD;
          addr_d  = '0;
          len_d   = len;
        end
      end

      ST_LOAD: begin
        if (!playHold) begin
          state_d = ST_ON;
          leds_d  = rom_data;
          tcnt_d  = '0;
        end
      end

      ST_ON: begin
        if (tick) begin
          if (tcnt_q == ON_LAST) begin
            state_d = ST_OFF;
            leds_d  = '0;
            tcnt_d  = '0;
          end else begin
            tcnt_d = tcnt_q + TC_ONE;
          end
        end
      end

      ST_OFF: begin
        if (tick) begin
          if (tcnt_q == OFF_LAST) begin
            tcnt_d = '0;
            if (addr_q == len_q) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_LOAD;
              addr_d  = addr_q + ADDR_ONE;
            end
          end else begin
            tcnt_d = tcnt_q + TC_ONE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        addr_d  = '0;
        len_d   = '0;
        leds_d  = '0;
        tcnt_d  = '0;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clock_50 or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      leds_q  <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      leds_q  <= leds_d;
      tcnt_q  <= tcnt_d;
    end
  end

  assign rom_addr = addr_q;
  assign leds     = leds_q;
  assign busy     = (state_q == ST_LOAD) || (state_q == ST_ON) ||
                    (state_q == ST_OFF);
  assign end_fpga = (state_q == ST_DONE);

  // Status outputs are mutually exclusive and LEDs are dark outside ON
  property pBusyDoneExclusive;
    @(posedge clock_50) disable iff (!reset) !(busy && end_fpga);
  endproperty
  assert property (pBusyDoneExclusive);

  property pLedsOnlyInOn;
    @(posedge clock_50) disable iff (!reset) (state_q != ST_ON) |-> (leds_q == '0);
  endproperty
  assert property (pLedsOnlyInOn);

endmodule

// File: tb/tb_seq_display_ctrl.sv
// Testbench for seq_display_ctrl with a scoreboard. The stimulus side
// computes the expected timeline of every step from the step-length
// arithmetic and pushes it into queues; the monitor pops entries whenever the
// LEDs light up or end_fpga rises. Build with +define+SEQ_PAUSE_EN to cover
// the pause feature; otherwise pause is driven randomly and must be ignored.
module tb_seq_display_ctrl;

  localparam int DIV     = 4;
  localparam int ONT     = 2;
  localparam int OFFT    = 1;
  localparam int STEP    = 1 + ONT * DIV + OFFT * DIV;
  localparam int INT_MAX = 32'h7fff_ffff;

  typedef struct {
    logic [3:0] pat;
    logic [3:0] addr;
    int         rise;
    int         fall;
  } step_t;

  logic       clock_50 = 1'b0;
  logic       reset    = 1'b1;
  logic       start    = 1'b0;
  logic [3:0] len      = 4'd0;
  logic       pause    = 1'b0;
  logic [3:0] rom_addr;
  logic [3:0] rom_data;
  logic [3:0] leds;
  logic       busy;
  logic       end_fpga;

  logic [3:0] romMem [16];

  int    edgeCnt    = 0;
  int    vectors    = 0;
  int    miscompares = 0;
  bit    inReset    = 1'b1;
  int    busyLo     = 0;
  int    busyHi     = 0;
  int    endLo      = INT_MAX;
  int    endHi      = INT_MAX;
  step_t expSteps[$];
  int    expEnds[$];

  seq_display_ctrl #(
    .CLK_DIV   (DIV),
    .ON_TICKS  (ONT),
    .OFF_TICKS (OFFT)
  ) dut (
    .clock_50 (clock_50),
    .reset    (reset),
    .start    (start),
    .len      (len),
    .pause    (pause),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .leds     (leds),
    .busy     (busy),
    .end_fpga (end_fpga)
  );

  // 100 MHz-style free-running clock for simulation
  always #5 clock_50 = ~clock_50;

  // Edge index of the most recent rising edge
  always @(posedge clock_50) edgeCnt <= edgeCnt + 1;

  // Asynchronous-read sequence ROM holding 0001, 0010, 0100, 1000 repeating
  initial begin
    for (int i = 0; i < 16; i++) romMem[i] = 4'b0001 << (i % 4);
  end
  assign rom_data = romMem[rom_addr];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)",
               name, actual, expected, edgeCnt);
    end
  endtask

  // Expected pattern for step s of a sequence, straight from the ROM contents
  function automatic logic [3:0] stepPattern(input int s);
    logic [3:0] one;
    one = 4'b0001;
    return one << (s % 4);
  endfunction

  // Issue one start and play (or abort) a run. ign1/ign2 are edge offsets of
  // extra start pulses while busy (0 = none); pStep/pLen place a pause burst
  // in the lit phase of one step; abortAt > 0 asserts reset at that offset.
  task automatic applyStimulus(input int lenVal, input int ign1, input int ign2,
                               input int pStep, input int pLen, input int abortAt);
    int    k;
    int    e;
    int    stopEdge;
    int    pFirst;
    int    tail;
    step_t st;

    k     = edgeCnt + 1;
    start = 1'b1;
    len   = lenVal[3:0];
    @(posedge clock_50); #1;
    start = 1'b0;

    busyLo = k;
    busyHi = k + STEP * (lenVal + 1) + pLen;
    endLo  = busyHi;
    endHi  = INT_MAX;
    for (int s = 0; s <= lenVal; s++) begin
      st.pat  = stepPattern(s);
      st.addr = s[3:0];
      st.rise = k + STEP * s + 1 + ((s > pStep) ? pLen : 0);
      st.fall = k + STEP * s + 1 + ONT * DIV + ((s >= pStep) ? pLen : 0);
      expSteps.push_back(st);
    end
    expEnds.push_back(busyHi);

    pFirst   = k + STEP * pStep + 4;
    tail     = $urandom_range(1, 4);
    stopEdge = (abortAt > 0) ? (k + abortAt) : (busyHi + tail);

    while (edgeCnt < stopEdge) begin
      e     = edgeCnt + 1;
      start = ((ign1 > 0) && (e == k + ign1)) || ((ign2 > 0) && (e == k + ign2));
      len   = 4'($urandom);
`ifdef SEQ_PAUSE_EN
      if (e > busyHi)
        pause = 1'($urandom);
      else
        pause = (pLen > 0) && (e >= pFirst) && (e < pFirst + pLen);
`else
      pause = 1'($urandom);
`endif
      @(posedge clock_50); #1;
    end
    start = 1'b0;

    if (abortAt > 0) begin
      inReset = 1'b1;
      #1 reset = 1'b0;
      #1;
      checkOutput("abort_rom_addr", 32'(rom_addr), 32'd0);
      checkOutput("abort_leds", 32'(leds), 32'd0);
      checkOutput("abort_busy", 32'(busy), 32'd0);
      checkOutput("abort_end_fpga", 32'(end_fpga), 32'd0);
      expSteps.delete();
      expEnds.delete();
      busyLo = 0;
      busyHi = 0;
      endLo  = INT_MAX;
      endHi  = INT_MAX;
      repeat (3) @(posedge clock_50);
      #2 reset = 1'b1;
      @(posedge clock_50); #1;
      inReset = 1'b0;
      // Nothing may play after release until a new start arrives
      repeat (20) begin
        len   = 4'($urandom);
        pause = 1'($urandom);
        @(posedge clock_50); #1;
      end
      pause = 1'b0;
    end
  endtask

  // Monitor: compares status windows every cycle and pops the scoreboard
  // whenever the LEDs light up or end_fpga rises
  initial begin
    logic [3:0] prevLeds;
    logic       prevEnd;
    step_t      cur;
    prevLeds = 4'd0;
    prevEnd  = 1'b0;
    cur.pat  = 4'd0;
    cur.addr = 4'd0;
    cur.rise = 0;
    cur.fall = 0;
    forever begin
      @(negedge clock_50);
      if (!inReset) begin
        checkOutput("busy", 32'(busy), 32'((edgeCnt >= busyLo) && (edgeCnt < busyHi)));
        checkOutput("end_fpga", 32'(end_fpga),
                    32'((edgeCnt >= endLo) && (edgeCnt < endHi)));
        if ((leds != 4'd0) && (prevLeds == 4'd0)) begin
          if (expSteps.size() == 0) begin
            checkOutput("unexpected_leds", 32'(leds), 32'd0);
          end else begin
            cur = expSteps.pop_front();
            checkOutput("leds_pattern", 32'(leds), 32'(cur.pat));
            checkOutput("rom_addr", 32'(rom_addr), 32'(cur.addr));
            checkOutput("leds_rise_edge", 32'(edgeCnt), 32'(cur.rise));
          end
        end else if (leds != 4'd0) begin
          checkOutput("leds_hold", 32'(leds), 32'(cur.pat));
        end else if (prevLeds != 4'd0) begin
          checkOutput("leds_fall_edge", 32'(edgeCnt), 32'(cur.fall));
        end
        if (end_fpga && !prevEnd) begin
          if (expEnds.size() == 0)
            checkOutput("unexpected_end", 32'(end_fpga), 32'd0);
          else
            checkOutput("end_rise_edge", 32'(edgeCnt), 32'(expEnds.pop_front()));
        end
      end
      prevLeds = leds;
      prevEnd  = end_fpga;
    end
  end

  // Main sequence: reset checks, directed runs, an aborted run, random runs
  initial begin
    int lenR;
    int span;
    int pStepR;
    int pLenR;

    #1 reset = 1'b0;
    #1;
    checkOutput("reset_rom_addr", 32'(rom_addr), 32'd0);
    checkOutput("reset_leds", 32'(leds), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_end_fpga", 32'(end_fpga), 32'd0);
    repeat (2) @(posedge clock_50);
    #2 reset = 1'b1;
    @(posedge clock_50); #1;
    inReset = 1'b0;
    repeat (3) @(posedge clock_50);
    #1;

    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(3, 0, 0, 0, 0, 0);
    applyStimulus(3, 5, 20, 0, 0, 0);
    applyStimulus(15, 0, 0, 0, 0, 0);
    applyStimulus(3, 0, 0, 0, 0, 30);
`ifdef SEQ_PAUSE_EN
    applyStimulus(3, 0, 0, 1, 10, 0);
`endif

    for (int r = 0; r < 10; r++) begin
      lenR  = $urandom_range(0, 15);
      span  = STEP * (lenR + 1);
      pStepR = 0;
      pLenR  = 0;
`ifdef SEQ_PAUSE_EN
      pStepR = $urandom_range(0, lenR);
      pLenR  = $urandom_range(1, 12);
`endif
      applyStimulus(lenR, $urandom_range(1, span - 1), $urandom_range(1, span - 1),
                    pStepR, pLenR, 0);
    end

    repeat (3) @(posedge clock_50);
    #1;
    checkOutput("leftover_steps", 32'(expSteps.size()), 32'd0);
    checkOutput("leftover_ends", 32'(expEnds.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seq_display_ctrl.md
SEQ_DISPLAY_CTRL -- requirements
Module: seq_display_ctrl

Interface
REQ-001 Parameter CLK_DIV, default 25_000_000, is the clock_50 cycles per tick (0.5 s at 50 MHz); legal range is 2 or more.
REQ-002 Parameter ON_TICKS, default 2, is the number of ticks each LED step is lit; legal range is 1 or more.
REQ-003 Parameter OFF_TICKS, default 1, is the number of blank ticks between steps; legal range is 1 or more.
REQ-004 Port clock_50, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port start, input, 1 bit: request to play the stored sequence, sampled on the clock edge.
REQ-007 Port len, input, 4 bits: index of the last step, so len+1 steps are played (1..16).
REQ-008 Port pause, input, 1 bit: freezes playback (active only with SEQ_PAUSE_EN).
REQ-009 Port rom_addr, output, 4 bits: address to the sequence ROM.
REQ-010 Port rom_data, input, 4 bits: one-hot LED pattern, valid one cycle after rom_addr changes.
REQ-011 Port leds, output, 4 bits: registered LED drive.
REQ-012 Port busy, output, 1 bit: high from LOAD through the final OFF state.
REQ-013 Port end_fpga, output, 1 bit: status level to the game controller, high while in DONE.

Function
REQ-014 The FSM SHALL have the states IDLE, LOAD, ON, OFF and DONE.
REQ-015 IDLE or DONE with start=1 SHALL go to LOAD, with rom_addr cleared to 0 and len latched into len_q.
- start while busy is ignored.
- len changes during playback have no effect.
REQ-016 LOAD SHALL last exactly 1 cycle, then go to ON.
- On that edge, leds takes rom_data and the tick prescaler clears.
REQ-017 ON SHALL go to OFF on the ON_TICKS-th tick.
- On that edge, leds goes to 0 and the prescaler clears.
REQ-018 OFF SHALL resolve on the OFF_TICKS-th tick:
- if rom_addr==len_q, go to DONE;
- otherwise rom_addr+1, then go to LOAD.
REQ-019 The tick SHALL be a 1-cycle pulse when the prescaler reaches CLK_DIV-1.
- The prescaler wraps to 0 on the tick.
- The tick count is held only in ON and OFF.
REQ-020 Each step SHALL take exactly 1 + ON_TICKS*CLK_DIV + OFF_TICKS*CLK_DIV cycles.
- If start is sampled at edge k, end_fpga rises at edge k + (len+1)*step.
REQ-021 rom_addr SHALL never wrap: len_q=15 ends after address 15.
REQ-022 busy and end_fpga SHALL never both be 1.
REQ-023 leds SHALL be 0 in every state except ON.

Reset
REQ-024 reset=0 SHALL immediately force:
- state IDLE;
- rom_addr, leds, prescaler, tick count and len_q to 0;
- busy and end_fpga to 0.
REQ-025 A reset assertion mid-playback SHALL abort the sequence.
- After release, nothing plays until a new start.

Configuration
REQ-026 With SEQ_PAUSE_EN defined, pause=1 SHALL freeze the state, prescaler, tick count, rom_addr and leds.
- Playback resumes on the cycle after pause falls.
- In IDLE or DONE, pause has no effect.
- A start arriving while paused follows REQ-015.
REQ-027 Without SEQ_PAUSE_EN, the pause port SHALL remain present and be ignored.

Structure
REQ-028 The package seq_pkg SHALL hold:
- the state enum;
- the address and LED widths (4);
- the default CLK_DIV, ON_TICKS and OFF_TICKS values.
REQ-029 Sub-module seq_tick_gen SHALL implement the prescaler, with clear, enable and tick ports.

Verification (CLK_DIV=4, ON_TICKS=2, OFF_TICKS=1, step=13 cycles; ROM holds 0001, 0010, 0100, 1000 repeating)
REQ-030 Scenario: start at edge 0 with len=0.
- leds=0001 during edges 1-8, 0 during edges 9-12.
- end_fpga=1 and busy=0 from edge 13.
REQ-031 Scenario: len=3.
- rom_addr steps 0..3 with leds 0001, 0010, 0100, 1000.
- end_fpga rises at edge 52.
REQ-032 Scenario: len=15.
- 16 steps, with no wrap of rom_addr.
- end_fpga rises at edge 208.
REQ-033 Scenario: start pulses at edges 5 and 20 while busy.
- Both are ignored; timing is identical to REQ-031.
- A start in DONE restarts playback, with end_fpga=0 on the next edge.
REQ-034 Scenario: reset=0 at edge 30 of a len=3 run.
- All outputs are 0 immediately.
- The block stays in IDLE with busy=0 until the next start.
REQ-035 Scenario (SEQ_PAUSE_EN): pause high for 10 cycles during ON of step 1.
- leds holds its value throughout.
- end_fpga rises at edge 62 (the unpaused timing plus 10).
